// File: rtl/if_fetch_pkg.sv
// Shared constants, FSM encoding and line-packing helper for the fetch stage.
package if_fetch_pkg;

  localparam int          IfToIdBusWidth     = 128;
  localparam int          LineIfToIdBusWidth = 64;
  localparam logic [31:0] ResetPc            = 32'h1C00_0000;
  localparam logic        RstEnable          = 1'b1;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } fetch_state_t;

  // One IF->ID line: pc in the upper word, instruction in the lower word.
  function automatic logic [LineIfToIdBusWidth-1:0] make_line(input logic [31:0] pc,
                                                              input logic [31:0] inst);
    return {pc, inst};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory handshake plus IF->ID pair hand-off.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                      inst_req_o;
  logic [31:0]               inst_addr_o;
  logic                      inst_addr_ok_i;
  logic                      inst_data_ok_i;
  logic [63:0]               inst_rdata_i;

  logic                      next_allowin_i;
  logic                      line1_valid_o;
  logic                      line2_valid_o;
  logic [IfToIdBusWidth-1:0] to_ifid_obus;

  modport master (
    output inst_req_o, inst_addr_o, line1_valid_o, line2_valid_o, to_ifid_obus,
    input  inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, next_allowin_i
  );

  modport slave (
    input  inst_req_o, inst_addr_o, line1_valid_o, line2_valid_o, to_ifid_obus,
    output inst_addr_ok_i, inst_data_ok_i, inst_rdata_i, next_allowin_i
  );

endinterface

// File: rtl/if_pc_gen.sv
// Fetch PC register: redirect mux (exception over branch) and aligned +8 step.
module if_pc_gen
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_target_i,
  input  logic        branch_flush_i,
  input  logic [31:0] branch_target_i,
  input  logic        advance,
  output logic        flush,
  output logic [31:0] fetch_pc
);

  logic [31:0] flush_target;

  // Redirect request and target; an exception outranks a branch in the same cycle.
  always_comb begin
    flush        = excep_flush_i | branch_flush_i;
    flush_target = excep_flush_i ? excep_target_i : branch_target_i;
  end

  // A redirect beats a coincident advance; the step wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      fetch_pc <= ResetPc;
    end else if (flush) begin
      fetch_pc <= flush_target;
    end else if (advance) begin
      fetch_pc <= {fetch_pc[31:3], 3'b000} + 32'd8;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding 64-bit read, pair buffer toward IF_ID.
//
// state | meaning
// IDLE  | one cycle after reset, no request
// REQ   | request driven, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok (cancel drops one response)
// HOLD  | pair buffered and presented, waiting for next_allowin_i
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_flush_i,
  input  logic [31:0] branch_target_i,
  input  logic        excep_flush_i,
  input  logic [31:0] excep_target_i,
  if_fetch_if.master  fetch_bus
);

  fetch_state_t state, next_state;
  logic         cancel, cancel_next;
  logic         flush;
  logic         fill, transfer;
  logic [31:0]  fetch_pc;

  logic [LineIfToIdBusWidth-1:0] buf_line1, buf_line2;
  logic                          buf_v1, buf_v2;

  if_pc_gen u_pc_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .excep_flush_i   (excep_flush_i),
    .excep_target_i  (excep_target_i),
    .branch_flush_i  (branch_flush_i),
    .branch_target_i (branch_target_i),
    .advance         (transfer),
    .flush           (flush),
    .fetch_pc        (fetch_pc)
  );

  // Next state, cancel tracking and the fill/transfer strobes.
  always_comb begin
    next_state  = state;
    cancel_next = cancel;
    fill        = 1'b0;
    transfer    = 1'b0;
    case (state)
      FETCH_IDLE: next_state = FETCH_REQ;
      FETCH_REQ: begin
        if (fetch_bus.inst_addr_ok_i) begin
          next_state = FETCH_WAIT;
          if (flush) cancel_next = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (fetch_bus.inst_data_ok_i) begin
          cancel_next = 1'b0;
          if (cancel || flush) begin
            next_state = FETCH_REQ;
          end else begin
            next_state = FETCH_HOLD;
            fill       = 1'b1;
          end
        end else if (flush) begin
          cancel_next = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (flush) begin
          next_state = FETCH_REQ;
        end else if (fetch_bus.next_allowin_i) begin
          next_state = FETCH_REQ;
          transfer   = 1'b1;
        end
      end
      default: next_state = FETCH_IDLE;
    endcase
  end

  // State and cancel registers.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      state  <= FETCH_IDLE;
      cancel <= 1'b0;
    end else begin
      state  <= next_state;
      cancel <= cancel_next;
    end
  end

  // Pair buffer: an odd-word pc keeps only the upper word as a single line.
  always_ff @(posedge clk) begin
    if (rst_n == RstEnable) begin
      buf_line1 <= '0;
      buf_line2 <= '0;
      buf_v1    <= 1'b0;
      buf_v2    <= 1'b0;
    end else if (fill) begin
      buf_v1 <= 1'b1;
      if (!fetch_pc[2]) begin
        buf_line1 <= make_line(fetch_pc, fetch_bus.inst_rdata_i[31:0]);
        buf_line2 <= make_line(fetch_pc + 32'd4, fetch_bus.inst_rdata_i[63:32]);
        buf_v2    <= 1'b1;
      end else begin
        buf_line1 <= make_line(fetch_pc, fetch_bus.inst_rdata_i[63:32]);
        buf_line2 <= '0;
        buf_v2    <= 1'b0;
      end
    end else if (flush || transfer) begin
      buf_v1 <= 1'b0;
      buf_v2 <= 1'b0;
    end
  end

  // Memory request and IF_ID outputs, all from registers.
  always_comb begin
    fetch_bus.inst_req_o    = (state == FETCH_REQ);
    fetch_bus.inst_addr_o   = {fetch_pc[31:3], 3'b000};
    fetch_bus.line1_valid_o = buf_v1 | buf_v2;
    fetch_bus.line2_valid_o = buf_v2;
    fetch_bus.to_ifid_obus  = {buf_line2, buf_line1};
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected addresses/pairs queued by stimulus, popped by monitors.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_flush_i, excep_flush_i;
  logic [31:0] branch_target_i, excep_target_i;

  if_fetch_if fbus();

  if_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_flush_i  (branch_flush_i),
    .branch_target_i (branch_target_i),
    .excep_flush_i   (excep_flush_i),
    .excep_target_i  (excep_target_i),
    .fetch_bus       (fbus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int delivered = 0;
  int cyc = 0;
  int deliv_cyc[$];
  logic [31:0]  exp_addr_q[$];
  logic [129:0] exp_pair_q[$];

  int          mem_lat = 0;
  logic        mem_acc = 1'b0;
  logic [31:0] mem_acc_addr = '0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_pend_addr = '0;
  int          mem_cnt = 0;
  logic        stray_ok = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // {line1_valid, line2_valid, to_ifid_obus} expected for a pair fetched at pc.
  function automatic logic [129:0] exp_pair(input logic [31:0] pc);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    if (pc[2]) return {1'b1, 1'b0, 64'h0, pc, word_at(pc)};
    return {1'b1, 1'b1, pc4, word_at(pc4), pc, word_at(pc)};
  endfunction

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!fbus.line1_valid_o && n < 200) begin step(); n++; end
    if (n >= 200) timeout_fail("wait_valid");
  endtask

  task automatic wait_delivered(input int target);
    int n = 0;
    while (delivered < target && n < 200) begin step(); n++; end
    if (n >= 200) timeout_fail("wait_delivered");
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!(fbus.inst_req_o && fbus.inst_addr_ok_i) && n < 200) begin step(); n++; end
    if (n >= 200) timeout_fail("wait_accept");
  endtask

  // Memory model: accepts when idle, returns {word(a+4), word(a)} after mem_lat extra cycles.
  initial begin
    fbus.inst_addr_ok_i = 1'b0;
    fbus.inst_data_ok_i = 1'b0;
    fbus.inst_rdata_i   = '0;
    forever begin
      @(posedge clk);
      #1;
      fbus.inst_addr_ok_i = 1'b0;
      fbus.inst_data_ok_i = 1'b0;
      if (rst_n) begin
        mem_acc  = 1'b0;
        mem_pend = 1'b0;
      end else begin
        if (mem_acc) begin
          mem_pend      = 1'b1;
          mem_pend_addr = mem_acc_addr;
          mem_cnt       = mem_lat;
          mem_acc       = 1'b0;
        end
        if (mem_pend) begin
          if (mem_cnt == 0) begin
            fbus.inst_data_ok_i = 1'b1;
            fbus.inst_rdata_i   = {word_at(mem_pend_addr + 32'd4), word_at(mem_pend_addr)};
            mem_pend = 1'b0;
          end else begin
            mem_cnt--;
          end
        end
        if (fbus.inst_req_o && !mem_pend) begin
          fbus.inst_addr_ok_i = 1'b1;
          mem_acc      = 1'b1;
          mem_acc_addr = fbus.inst_addr_o;
        end
      end
      if (stray_ok) begin
        fbus.inst_data_ok_i = 1'b1;
        fbus.inst_rdata_i   = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
  end

  // Monitor: accepted request addresses and delivered pairs against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n && fbus.inst_req_o && fbus.inst_addr_ok_i) begin
      if (exp_addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL req_addr: got %h expected none", fbus.inst_addr_o);
      end else begin
        check("req_addr", fbus.inst_addr_o, exp_addr_q.pop_front());
      end
    end
    if (!rst_n && fbus.line1_valid_o && fbus.next_allowin_i && !(branch_flush_i || excep_flush_i)) begin
      if (exp_pair_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pair: got %h expected none", fbus.to_ifid_obus);
      end else begin
        check("pair", {fbus.line1_valid_o, fbus.line2_valid_o, fbus.to_ifid_obus}, exp_pair_q.pop_front());
      end
      delivered++;
      deliv_cyc.push_back(cyc);
    end
    if (fbus.line2_valid_o && !fbus.line1_valid_o) begin
      tests++;
      fails++;
      $display("FAIL line2_without_line1: got l1=0 l2=1 expected l1=1");
    end
  end

  initial begin
    rst_n = 1'b1;
    branch_flush_i = 1'b0;
    excep_flush_i = 1'b0;
    branch_target_i = '0;
    excep_target_i = '0;
    fbus.next_allowin_i = 1'b0;

    // reset state
    step(); step(); #3;
    check("rst_req", fbus.inst_req_o, 1'b0);
    check("rst_v1", fbus.line1_valid_o, 1'b0);
    check("rst_v2", fbus.line2_valid_o, 1'b0);
    check("rst_bus", fbus.to_ifid_obus, 128'h0);
    exp_addr_q.push_back(32'h1C00_0000);
    step(); rst_n = 1'b0; #3;
    check("idle_req", fbus.inst_req_o, 1'b0);
    check("idle_v1", fbus.line1_valid_o, 1'b0);
    check("idle_bus", fbus.to_ifid_obus, 128'h0);

    // hold with next_allowin low: stable outputs, no request
    exp_pair_q.push_back(exp_pair(32'h1C00_0000));
    step(); wait_valid();
    for (int i = 0; i < 5; i++) begin
      #3;
      check("hold_out", {fbus.line1_valid_o, fbus.line2_valid_o, fbus.to_ifid_obus}, exp_pair(32'h1C00_0000));
      check("hold_req", fbus.inst_req_o, 1'b0);
      step();
    end

    // streaming at zero wait: 1C000000 then 1C000008, three cycles apart
    exp_addr_q.push_back(32'h1C00_0008);
    exp_pair_q.push_back(exp_pair(32'h1C00_0008));
    exp_addr_q.push_back(32'h1C00_0010);
    fbus.next_allowin_i = 1'b1;
    wait_delivered(2);
    fbus.next_allowin_i = 1'b0;
    if (deliv_cyc.size() >= 2) check("throughput", deliv_cyc[1] - deliv_cyc[0], 3);
    else timeout_fail("throughput");

    // branch flush during WAIT: response dropped, single-line pair at 1C000104
    step(); wait_valid();
    mem_lat = 2;
    exp_pair_q.push_back(exp_pair(32'h1C00_0010));
    exp_addr_q.push_back(32'h1C00_0018);
    fbus.next_allowin_i = 1'b1;
    wait_delivered(3);
    fbus.next_allowin_i = 1'b0;
    wait_accept();
    exp_addr_q.push_back(32'h1C00_0100);
    exp_pair_q.push_back(exp_pair(32'h1C00_0104));
    exp_addr_q.push_back(32'h1C00_0108);
    step();
    branch_flush_i = 1'b1; branch_target_i = 32'h1C00_0104;
    step();
    branch_flush_i = 1'b0;
    fbus.next_allowin_i = 1'b1;
    wait_delivered(4);
    fbus.next_allowin_i = 1'b0;
    mem_lat = 0;

    // both flushes coincident with a HOLD transfer: exception target wins
    step(); wait_valid();
    exp_addr_q.push_back(32'h1C00_8000);
    exp_pair_q.push_back(exp_pair(32'h1C00_8000));
    exp_addr_q.push_back(32'h1C00_8008);
    fbus.next_allowin_i = 1'b1;
    branch_flush_i = 1'b1; branch_target_i = 32'h1C00_0200;
    excep_flush_i = 1'b1; excep_target_i = 32'h1C00_8000;
    step();
    branch_flush_i = 1'b0; excep_flush_i = 1'b0;
    wait_delivered(5);
    fbus.next_allowin_i = 1'b0;

    // flush in the same cycle as addr_ok: exactly one response dropped
    step(); wait_valid();
    exp_pair_q.push_back(exp_pair(32'h1C00_8008));
    exp_addr_q.push_back(32'h1C00_8010);
    fbus.next_allowin_i = 1'b1;
    wait_delivered(6);
    wait_accept();
    fbus.next_allowin_i = 1'b0;
    branch_flush_i = 1'b1; branch_target_i = 32'h1C00_0300;
    exp_addr_q.push_back(32'h1C00_0300);
    exp_pair_q.push_back(exp_pair(32'h1C00_0300));
    exp_addr_q.push_back(32'h1C00_0308);
    step();
    branch_flush_i = 1'b0;
    fbus.next_allowin_i = 1'b1;
    wait_delivered(7);
    fbus.next_allowin_i = 1'b0;

    // second flush while cancel pending, then fetch across the 2^32 wrap
    step(); wait_valid();
    mem_lat = 3;
    exp_pair_q.push_back(exp_pair(32'h1C00_0308));
    exp_addr_q.push_back(32'h1C00_0310);
    fbus.next_allowin_i = 1'b1;
    wait_delivered(8);
    fbus.next_allowin_i = 1'b0;
    wait_accept();
    exp_addr_q.push_back(32'hFFFF_FFF8);
    exp_pair_q.push_back(exp_pair(32'hFFFF_FFF8));
    exp_addr_q.push_back(32'h0000_0000);
    step();
    branch_flush_i = 1'b1; branch_target_i = 32'h1C00_0400;
    step();
    branch_flush_i = 1'b0;
    excep_flush_i = 1'b1; excep_target_i = 32'hFFFF_FFF8;
    step();
    excep_flush_i = 1'b0;
    fbus.next_allowin_i = 1'b1;
    wait_delivered(9);
    fbus.next_allowin_i = 1'b0;

    // reset in WAIT, stray data_ok in IDLE ignored
    wait_accept();
    step();
    rst_n = 1'b1;
    step(); step(); #3;
    check("rst2_req", fbus.inst_req_o, 1'b0);
    check("rst2_v1", fbus.line1_valid_o, 1'b0);
    check("rst2_v2", fbus.line2_valid_o, 1'b0);
    check("rst2_bus", fbus.to_ifid_obus, 128'h0);
    mem_lat = 0;
    exp_addr_q.push_back(32'h1C00_0000);
    exp_pair_q.push_back(exp_pair(32'h1C00_0000));
    exp_addr_q.push_back(32'h1C00_0008);
    stray_ok = 1'b1;
    step();
    rst_n = 1'b0;
    stray_ok = 1'b0;
    #3;
    check("idle2_req", fbus.inst_req_o, 1'b0);
    check("idle2_v1", fbus.line1_valid_o, 1'b0);
    check("idle2_bus", fbus.to_ifid_obus, 128'h0);
    step();
    fbus.next_allowin_i = 1'b1;
    wait_delivered(10);
    fbus.next_allowin_i = 1'b0;

    repeat (10) step();
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("pair_q_empty", exp_pair_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
